// File: rtl/mixcolumns_seq.sv
// mixcolumns_seq: iterative AES MixColumns, one column per cycle through a shared column unit, per-block bypass.
// Latency: accept->out_valid is 4 cycles for a mixed block, 0 extra cycles for a bypassed block.
// Backpressure: one block in flight; DONE holds out_state/out_valid until out_ready, in_ready only in IDLE.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_state (128b, byte 0 in [127:120]) and in_bypass sampled on accept
//   out_valid/out_ready  output handshake; out_state is the internal state register
//   busy, col_idx        RUN indicator and column currently in the column unit (0 outside RUN)

// transformColumn: one AES MixColumns column in GF(2^8) mod 0x11B.
// Latency: purely combinational.
// Backpressure: none, no state.
module transformColumn (
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3
);

    // Multiply by x in GF(2^8); fold the overflow bit back with 0x1B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] d0, d1, d2, d3;

    always_comb begin
        d0 = xtime(in0);
        d1 = xtime(in1);
        d2 = xtime(in2);
        d3 = xtime(in3);
        // 3*v is computed as 2*v ^ v.
        out0 = d0 ^ (d1 ^ in1) ^ in2 ^ in3;
        out1 = in0 ^ d1 ^ (d2 ^ in2) ^ in3;
        out2 = in0 ^ in1 ^ d2 ^ (d3 ^ in3);
        out3 = (d0 ^ in0) ^ in1 ^ in2 ^ d3;
    end

endmodule

module mixcolumns_seq #(
    parameter logic BYPASS_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy,
    output logic [1:0]   col_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [1:0]   col;
    logic [127:0] st;
    logic         byp;

    logic [31:0]  col_word;
    logic [31:0]  mix_word;
    logic         accept;
    logic         mix_en;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and decoded outputs (outputs depend on state only)
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        col_idx   = 2'd0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (in_bypass && BYPASS_EN) ? DONE : RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                col_idx = col;
                if (col == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = (state_q == IDLE) && in_valid;
    // A bypassed block never enters RUN; qualifying with byp keeps the
    // datapath from touching a block that was flagged pass-through.
    assign mix_en = (state_q == RUN) && !byp;

    // ------------------------------------------------------------------
    // Column select: column c occupies bytes 4c..4c+3, row 0 in the MSB.
    // ------------------------------------------------------------------
    always_comb begin
        col_word = st[127:96];
        case (col)
            2'd0:    col_word = st[127:96];
            2'd1:    col_word = st[95:64];
            2'd2:    col_word = st[63:32];
            2'd3:    col_word = st[31:0];
            default: col_word = st[127:96];
        endcase
    end

    transformColumn u_col (
        .in0  (col_word[31:24]),
        .in1  (col_word[23:16]),
        .in2  (col_word[15:8]),
        .in3  (col_word[7:0]),
        .out0 (mix_word[31:24]),
        .out1 (mix_word[23:16]),
        .out2 (mix_word[15:8]),
        .out3 (mix_word[7:0])
    );

    // ------------------------------------------------------------------
    // State register, column counter, bypass flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st  <= 128'd0;
            col <= 2'd0;
            byp <= 1'b0;
        end else if (accept) begin
            st  <= in_state;
            col <= 2'd0;
            byp <= in_bypass & BYPASS_EN;
        end else if (mix_en) begin
            case (col)
                2'd0:    st[127:96] <= mix_word;
                2'd1:    st[95:64]  <= mix_word;
                2'd2:    st[63:32]  <= mix_word;
                2'd3:    st[31:0]   <= mix_word;
                default: st[127:96] <= mix_word;
            endcase
            // Wraps to 0 after the last column.
            col <= col + 2'd1;
        end
    end

    assign out_state = st;

endmodule

// File: tb/tb_mixcolumns_seq.sv
// tb_mixcolumns_seq: scoreboard bench for mixcolumns_seq (directed FIPS/bypass/backpressure/reset plus random).
// Latency: n/a (bench).
// Backpressure: drives random and directed out_ready stalls.
module tb_mixcolumns_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;
    logic [1:0]   col_idx;

    // Second instance with bypass disabled.
    logic         nb_in_valid;
    logic         nb_in_ready;
    logic [127:0] nb_in_state;
    logic         nb_in_bypass;
    logic         nb_out_valid;
    logic         nb_out_ready;
    logic [127:0] nb_out_state;
    logic         nb_busy;
    logic [1:0]   nb_col_idx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cnt  = 0;

    logic [127:0] exp_q[$];
    int           xfer_cyc[$];

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] BYP_IN   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] BYP_MIX  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    mixcolumns_seq #(.BYPASS_EN(1'b1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy),
        .col_idx   (col_idx)
    );

    mixcolumns_seq #(.BYPASS_EN(1'b0)) u_dut_nb (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (nb_in_valid),
        .in_ready  (nb_in_ready),
        .in_state  (nb_in_state),
        .in_bypass (nb_in_bypass),
        .out_valid (nb_out_valid),
        .out_ready (nb_out_ready),
        .out_state (nb_out_state),
        .busy      (nb_busy),
        .col_idx   (nb_col_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model, written independently of the RTL structure.
    function automatic logic [7:0] xt(input logic [7:0] b);
        logic [7:0] r;
        r = b << 1;
        if (b[7]) r = r ^ 8'h1b;
        return r;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic byp);
        logic [127:0] r;
        logic [7:0] a, b, c, d;
        r = s;
        if (!byp) begin
            for (int k = 0; k < 4; k++) begin
                a = s[127 - 32*k -: 8];
                b = s[119 - 32*k -: 8];
                c = s[111 - 32*k -: 8];
                d = s[103 - 32*k -: 8];
                r[127 - 32*k -: 8] = xt(a) ^ xt(b) ^ b ^ c ^ d;
                r[119 - 32*k -: 8] = a ^ xt(b) ^ xt(c) ^ c ^ d;
                r[111 - 32*k -: 8] = a ^ b ^ xt(c) ^ xt(d) ^ d;
                r[103 - 32*k -: 8] = xt(a) ^ a ^ b ^ c ^ xt(d);
            end
        end
        return r;
    endfunction

    // Scoreboard: push on accept, pop and compare on output transfer.
    // Sampled on the falling edge; the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("no_overlap", {127'd0, in_ready & out_valid}, 128'd0);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_state, in_bypass));
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 128'd1, 128'd0);
                end else begin
                    chk("sb_data", out_state, exp_q.pop_front());
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, {127'd0, out_valid}, 128'd0);
        chk({tag, "_busy"},      {127'd0, busy},      128'd0);
        chk({tag, "_col_idx"},   {126'd0, col_idx},   128'd0);
        chk({tag, "_in_ready"},  {127'd0, in_ready},  128'd1);
        chk({tag, "_out_state"}, out_state,           128'd0);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [127:0] s, input logic byp);
        in_state  = s;
        in_bypass = byp;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("send_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] s3[3];
        int t;

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_state     = '0;
        in_bypass    = 1'b0;
        out_ready    = 1'b0;
        nb_in_valid  = 1'b0;
        nb_in_state  = '0;
        nb_in_bypass = 1'b0;
        nb_out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ---- FIPS-197 mixed block: latency and column sequence ----
        out_ready = 1'b1;
        send(FIPS_IN, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fips_busy",    {127'd0, busy},      128'd1);
            chk("fips_col_idx", {126'd0, col_idx},   128'(k));
            chk("fips_no_vld",  {127'd0, out_valid}, 128'd0);
        end
        @(negedge clk);
        chk("fips_out_valid", {127'd0, out_valid}, 128'd1);
        chk("fips_out_state", out_state, FIPS_OUT);
        @(posedge clk);
        #1;
        chk("fips_idle", {127'd0, in_ready}, 128'd1);

        // ---- Bypass block ----
        send(BYP_IN, 1'b1);
        @(negedge clk);
        chk("byp_out_valid", {127'd0, out_valid}, 128'd1);
        chk("byp_out_state", out_state, BYP_IN);
        @(posedge clk);
        #1;
        chk("byp_idle", {127'd0, in_ready}, 128'd1);

        // ---- Bypass request on the BYPASS_EN=0 instance ----
        nb_in_state  = BYP_IN;
        nb_in_bypass = 1'b1;
        nb_in_valid  = 1'b1;
        nb_out_ready = 1'b1;
        @(negedge clk);
        chk("nb_in_ready", {127'd0, nb_in_ready}, 128'd1);
        @(posedge clk);
        #1;
        nb_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("nb_busy",   {127'd0, nb_busy},      128'd1);
            chk("nb_no_vld", {127'd0, nb_out_valid}, 128'd0);
        end
        @(negedge clk);
        chk("nb_out_valid", {127'd0, nb_out_valid}, 128'd1);
        chk("nb_out_state", nb_out_state, BYP_MIX);
        @(posedge clk);
        #1;

        // ---- Backpressure in DONE ----
        out_ready = 1'b0;
        send(FIPS_IN, 1'b0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
            chk("bp_out_state", out_state, FIPS_OUT);
            chk("bp_in_ready",  {127'd0, in_ready},  128'd0);
            @(posedge clk);
            #1;
            in_valid = (i == 3);
            in_state = 128'h0123456789abcdef_fedcba9876543210;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("bp_release_idle", {127'd0, in_ready}, 128'd1);
        chk("bp_q_empty", 128'(exp_q.size()), 128'd0);

        // ---- Back-to-back with in_valid held high ----
        s3[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
        s3[1] = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
        s3[2] = 128'h63cab704_0953d051_cd60e0e7_ba70e18c;
        xfer_cyc.delete();
        in_bypass = 1'b0;
        in_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_state = s3[j];
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("b2b_accept_wait", {127'd0, (t >= 20)}, 128'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_count", 128'(xfer_cyc.size()), 128'd3);
        if (xfer_cyc.size() == 3) begin
            chk("b2b_gap0", 128'(xfer_cyc[1] - xfer_cyc[0]), 128'd6);
            chk("b2b_gap1", 128'(xfer_cyc[2] - xfer_cyc[1]), 128'd6);
        end
        chk("b2b_q_empty", 128'(exp_q.size()), 128'd0);

        // ---- Reset in the middle of RUN ----
        send(BYP_IN, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_col_idx", {126'd0, col_idx}, 128'd2);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(FIPS_IN, 1'b0);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("mid_fresh_out_state", out_state, FIPS_OUT);
        @(posedge clk);
        #1;

        // ---- Random traffic ----
        acc_cnt = 0;
        t = 0;
        while (acc_cnt < 1000 && t < 40000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_bypass = 1'($urandom_range(0, 1));
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            t++;
        end
        chk("rnd_budget", {127'd0, (acc_cnt < 1000)}, 128'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rnd_drain", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
